// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the keypad row scanner.
//   scan_state_e : scanner FSM states
//   KEY_CODE_W   : width of the reported {row, col} key code
//   ROW_W/COL_W  : encoded row / column widths
//   NUM_ROWS/NUM_COLS : matrix dimensions
//   lowest_col() : priority select of the lowest set column
package keypad_scan_pkg;

  localparam int unsigned KEY_CODE_W = 5;
  localparam int unsigned ROW_W      = 3;
  localparam int unsigned COL_W      = 2;
  localparam int unsigned NUM_ROWS   = 8;
  localparam int unsigned NUM_COLS   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive,
    StReport
  } scan_state_e;

  // Index of the lowest set bit; 0 when none is set (callers check for non-zero first).
  function automatic logic [COL_W-1:0] lowest_col(input logic [NUM_COLS-1:0] cols);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (cols[i]) idx = COL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Loadable down-counter with a terminal-count flag, shared by the settle and
// dwell phases of the row scanner.
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset, clears the count
//   load       : load load_value this cycle (takes priority over counting)
//   load_value : value to load (N-1 for an N-cycle phase)
//   terminal   : count is zero
module scan_dwell_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == '0);

endmodule

// File: rtl/keypad_row_scanner.sv
// Keypad row scan sequencer feeding a 3-to-8 row decoder. Walks rows 0..7
// with a blanked settle phase and a driven dwell phase, samples the column bus
// on the last dwell cycle and reports each newly pressed key once over a
// valid/ready handshake. Scanning stalls while a report is pending.
//   Clk_In          : clock
//   Reset_N_In      : synchronous active-low reset
//   Scan_Enable_In  : 1 = scan, 0 = return to idle and forget pressed keys
//   Column_In       : column sense of the driven row, active-high
//   Row_Select_Out  : encoded row to the decoder select
//   Row_Blank_Out   : 1 = decoder outputs forced low
//   Key_Valid_Out   : key code available
//   Key_Ready_In    : consumer accepts key code
//   Key_Code_Out    : {row, col} of the reported press
//   Frame_Done_Out  : one-cycle pulse when the scanner leaves row 7
module keypad_row_scanner
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DWELL_CYCLES  = 16
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic                  Scan_Enable_In,
  input  logic [NUM_COLS-1:0]   Column_In,
  output logic [ROW_W-1:0]      Row_Select_Out,
  output logic                  Row_Blank_Out,
  output logic                  Key_Valid_Out,
  input  logic                  Key_Ready_In,
  output logic [KEY_CODE_W-1:0] Key_Code_Out,
  output logic                  Frame_Done_Out
);

  localparam int unsigned MAX_CYCLES =
      (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);

  scan_state_e                      state_q, state_d;
  logic [ROW_W-1:0]                 row_q, row_d;
  logic [NUM_ROWS*NUM_COLS-1:0]     map_q, map_d;
  logic [KEY_CODE_W-1:0]            code_q, code_d;
  logic                             frame_q, frame_d;
  logic                             blank_q, valid_q;

  logic                             cnt_load;
  logic [CNT_W-1:0]                 cnt_value;
  logic                             cnt_done;

  logic [KEY_CODE_W-1:0]            row_base;
  logic [NUM_COLS-1:0]              map_row;
  logic [NUM_COLS-1:0]              new_cols;
  logic                             last_row;

  scan_dwell_counter #(
    .WIDTH (CNT_W)
  ) u_counter (
    .clk        (Clk_In),
    .reset_n    (Reset_N_In),
    .load       (cnt_load),
    .load_value (cnt_value),
    .terminal   (cnt_done)
  );

  assign row_base = {row_q, {COL_W{1'b0}}};
  assign map_row  = map_q[row_base +: NUM_COLS];
  // A press is new only if it was not already reported and still held.
  assign new_cols = Column_In & ~map_row;
  assign last_row = (row_q == ROW_W'(NUM_ROWS - 1));

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    map_d     = map_q;
    code_d    = code_q;
    frame_d   = 1'b0;
    cnt_load  = 1'b0;
    cnt_value = SETTLE_LOAD;

    unique case (state_q)
      StIdle: begin
        if (Scan_Enable_In) begin
          state_d  = StBlank;
          row_d    = '0;
          cnt_load = 1'b1;
        end
      end
      StBlank: begin
        if (cnt_done) begin
          state_d   = StDrive;
          cnt_load  = 1'b1;
          cnt_value = DWELL_LOAD;
        end
      end
      StDrive: begin
        if (cnt_done) begin
          // Released keys drop out of the map; held ones stay reported.
          map_d[row_base +: NUM_COLS] = map_row & Column_In;
          if (new_cols != '0) begin
            state_d = StReport;
            code_d  = {row_q, lowest_col(new_cols)};
          end else begin
            state_d  = StBlank;
            row_d    = row_q + ROW_W'(1);
            frame_d  = last_row;
            cnt_load = 1'b1;
          end
        end
      end
      StReport: begin
        if (Key_Ready_In) begin
          map_d[code_q] = 1'b1;
          state_d       = StBlank;
          row_d         = row_q + ROW_W'(1);
          frame_d       = last_row;
          cnt_load      = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!Scan_Enable_In) begin
      state_d  = StIdle;
      row_d    = '0;
      map_d    = '0;
      frame_d  = 1'b0;
      cnt_load = 1'b0;
    end
  end

  always_ff @(posedge Clk_In) begin
    if (!Reset_N_In) begin
      state_q <= StIdle;
      row_q   <= '0;
      map_q   <= '0;
      code_q  <= '0;
      frame_q <= 1'b0;
      blank_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      map_q   <= map_d;
      code_q  <= code_d;
      frame_q <= frame_d;
      // Flag outputs come straight from flops, decoded from the next state.
      blank_q <= (state_d != StDrive);
      valid_q <= (state_d == StReport);
    end
  end

  assign Row_Select_Out = row_q;
  assign Row_Blank_Out  = blank_q;
  assign Key_Valid_Out  = valid_q;
  assign Key_Code_Out   = code_q;
  assign Frame_Done_Out = frame_q;

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Bench for keypad_row_scanner: a default-timing instance and a 1/1-cycle
// instance share enable/ready/reset; each sees the columns of a simulated key
// matrix for the row it drives. Both are checked every cycle against a model
// that tracks position within the row period, plus literal expectations.
module tb_keypad_row_scanner;

  logic       clk = 1'b0;
  logic       rst_n, en, ready;
  logic [3:0] col     [2];
  logic [2:0] row_sel [2];
  logic       blank   [2];
  logic       valid   [2];
  logic       frame   [2];
  logic [4:0] code    [2];
  logic [3:0] keys    [8];

  int         checks = 0;
  int         errors = 0;
  logic [4:0] xfers[$];

  // Model state
  int         s_cyc [2];
  int         d_cyc [2];
  bit         m_idle [2];
  bit         m_rep  [2];
  int         m_pos  [2];
  int         m_row  [2];
  bit [31:0]  m_map  [2];
  bit [4:0]   m_code [2];
  bit         m_frame[2];

  always #5 clk = ~clk;

  keypad_row_scanner #(
    .SETTLE_CYCLES (4),
    .DWELL_CYCLES  (16)
  ) u_dut_std (
    .Clk_In         (clk),
    .Reset_N_In     (rst_n),
    .Scan_Enable_In (en),
    .Column_In      (col[0]),
    .Row_Select_Out (row_sel[0]),
    .Row_Blank_Out  (blank[0]),
    .Key_Valid_Out  (valid[0]),
    .Key_Ready_In   (ready),
    .Key_Code_Out   (code[0]),
    .Frame_Done_Out (frame[0])
  );

  keypad_row_scanner #(
    .SETTLE_CYCLES (1),
    .DWELL_CYCLES  (1)
  ) u_dut_fast (
    .Clk_In         (clk),
    .Reset_N_In     (rst_n),
    .Scan_Enable_In (en),
    .Column_In      (col[1]),
    .Row_Select_Out (row_sel[1]),
    .Row_Blank_Out  (blank[1]),
    .Key_Valid_Out  (valid[1]),
    .Key_Ready_In   (ready),
    .Key_Code_Out   (code[1]),
    .Frame_Done_Out (frame[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic advance_row(input int k);
    m_frame[k] = (m_row[k] == 7);
    m_row[k]   = (m_row[k] + 1) % 8;
    m_pos[k]   = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs seen at that edge.
  task automatic model_step(input int k, input bit rn, input bit e, input bit [3:0] c,
                            input bit rdy);
    int found;
    m_frame[k] = 1'b0;
    if (!rn) begin
      m_idle[k] = 1; m_rep[k] = 0; m_pos[k] = 0; m_row[k] = 0; m_map[k] = '0; m_code[k] = '0;
    end else if (!e) begin
      m_idle[k] = 1; m_rep[k] = 0; m_pos[k] = 0; m_row[k] = 0; m_map[k] = '0;
    end else if (m_idle[k]) begin
      m_idle[k] = 0; m_pos[k] = 0; m_row[k] = 0;
    end else if (m_rep[k]) begin
      if (rdy) begin
        m_map[k][m_code[k]] = 1'b1;
        m_rep[k] = 0;
        advance_row(k);
      end
    end else if (m_pos[k] == s_cyc[k] + d_cyc[k] - 1) begin
      found = -1;
      for (int i = 0; i < 4; i++) if (!c[i]) m_map[k][m_row[k] * 4 + i] = 1'b0;
      for (int i = 3; i >= 0; i--) if (c[i] && !m_map[k][m_row[k] * 4 + i]) found = i;
      if (found >= 0) begin
        m_rep[k]  = 1;
        m_code[k] = 5'(m_row[k] * 4 + found);
      end else begin
        advance_row(k);
      end
    end else begin
      m_pos[k]++;
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      col[k] = $isunknown(row_sel[k]) ? 4'b0 : keys[row_sel[k]];
    end
    if (valid[0] === 1'b1 && ready) xfers.push_back(code[0]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, rst_n, en, col[k], ready);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_row", k), 32'(row_sel[k]), 32'(m_row[k]));
      check($sformatf("dut%0d_blank", k), 32'(blank[k]),
            32'(m_idle[k] || m_rep[k] || (m_pos[k] < s_cyc[k])));
      check($sformatf("dut%0d_valid", k), 32'(valid[k]), 32'(m_rep[k]));
      check($sformatf("dut%0d_frame", k), 32'(frame[k]), 32'(m_frame[k]));
      if (m_rep[k]) check($sformatf("dut%0d_code", k), 32'(code[k]), 32'(m_code[k]));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (valid[0] !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(valid[0]), 32'd1);
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    tick();
    for (int r = 0; r < 8; r++) keys[r] = 4'b0;
  endtask

  initial begin
    s_cyc[0] = 4; d_cyc[0] = 16;
    s_cyc[1] = 1; d_cyc[1] = 1;
    for (int r = 0; r < 8; r++) keys[r] = 4'b0;
    col[0] = 4'b0; col[1] = 4'b0;
    rst_n = 1'b0; en = 1'b1; ready = 1'b0;

    // Reset with enable asserted
    run(3);
    for (int k = 0; k < 2; k++) begin
      check("rst_row", 32'(row_sel[k]), 32'd0);
      check("rst_blank", 32'(blank[k]), 32'd1);
      check("rst_valid", 32'(valid[k]), 32'd0);
      check("rst_code", 32'(code[k]), 32'd0);
      check("rst_frame", 32'(frame[k]), 32'd0);
    end

    // First frame timing, no keys
    rst_n = 1'b1;
    for (int t = 1; t <= 161; t++) begin
      tick();
      if (t == 1) check("fast_t1_blank", 32'(blank[1]), 32'd1);
      if (t == 2) check("fast_t2_drive", 32'(blank[1]), 32'd0);
      if (t == 3) check("fast_t3_row", 32'(row_sel[1]), 32'd1);
      if (t == 17) check("fast_frame", 32'(frame[1]), 32'd1);
      if (t == 4) check("std_t4_blank", 32'(blank[0]), 32'd1);
      if (t == 5) check("std_t5_drive", 32'(blank[0]), 32'd0);
      if (t == 20) check("std_t20_row", 32'(row_sel[0]), 32'd0);
      if (t == 21) check("std_t21_row", 32'(row_sel[0]), 32'd1);
      if (t == 21) check("std_t21_blank", 32'(blank[0]), 32'd1);
      if (t == 160) check("std_t160_frame", 32'(frame[0]), 32'd0);
      if (t == 161) check("std_t161_frame", 32'(frame[0]), 32'd1);
      if (t == 161) check("std_t161_row", 32'(row_sel[0]), 32'd0);
    end

    // Single key on row 5, reported once while held
    keys[5] = 4'b0100;
    ready = 1'b1;
    xfers.delete();
    run(520);
    check("r5_count", 32'(xfers.size()), 32'd1);
    if (xfers.size() > 0) check("r5_code", 32'(xfers[0]), 32'b10110);
    keys[5] = 4'b0000;
    run(200);
    xfers.delete();
    keys[5] = 4'b0100;
    run(200);
    check("r5_again_count", 32'(xfers.size()), 32'd1);
    if (xfers.size() > 0) check("r5_again_code", 32'(xfers[0]), 32'b10110);

    // Two keys in row 2: one per frame, lowest first
    restart();
    keys[2] = 4'b1010;
    en = 1'b1;
    xfers.delete();
    run(340);
    check("r2_count", 32'(xfers.size()), 32'd2);
    if (xfers.size() == 2) begin
      check("r2_first", 32'(xfers[0]), 32'b01001);
      check("r2_second", 32'(xfers[1]), 32'b01011);
    end

    // Back-pressure at row 7
    restart();
    keys[7] = 4'b0001;
    ready = 1'b0;
    en = 1'b1;
    wait_valid(400);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(valid[0]), 32'd1);
      check("bp_code", 32'(code[0]), 32'b11100);
      check("bp_row", 32'(row_sel[0]), 32'd7);
      check("bp_blank", 32'(blank[0]), 32'd1);
    end
    ready = 1'b1;
    tick();
    check("bp_xfer_frame", 32'(frame[0]), 32'd1);
    check("bp_xfer_row", 32'(row_sel[0]), 32'd0);
    check("bp_xfer_valid", 32'(valid[0]), 32'd0);

    // Disable mid-DRIVE of row 3, then re-enable
    restart();
    keys[3] = 4'b0001;
    en = 1'b1;
    begin
      int n = 0;
      while (!(row_sel[0] == 3'd3 && blank[0] == 1'b0) && n < 200) begin
        tick();
        n++;
      end
      check("row3_drive_reached", 32'(n < 200), 32'd1);
    end
    en = 1'b0;
    tick();
    check("dis_drive_valid", 32'(valid[0]), 32'd0);
    check("dis_drive_row", 32'(row_sel[0]), 32'd0);
    check("dis_drive_blank", 32'(blank[0]), 32'd1);
    en = 1'b1;
    ready = 1'b1;
    xfers.delete();
    run(200);
    check("reen_count", 32'(xfers.size()), 32'd1);
    if (xfers.size() > 0) check("reen_code", 32'(xfers[0]), 32'b01100);

    // Disable while a report is pending
    en = 1'b0;
    tick();
    ready = 1'b0;
    en = 1'b1;
    wait_valid(200);
    check("pend_code", 32'(code[0]), 32'b01100);
    en = 1'b0;
    tick();
    check("dis_rep_valid", 32'(valid[0]), 32'd0);
    check("dis_rep_row", 32'(row_sel[0]), 32'd0);
    en = 1'b1;
    ready = 1'b1;
    xfers.delete();
    run(200);
    check("pend_reen_count", 32'(xfers.size()), 32'd1);
    if (xfers.size() > 0) check("pend_reen_code", 32'(xfers[0]), 32'b01100);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        for (int r = 0; r < 8; r++) keys[r] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      end
      ready = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 299) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
